state_sequencer: RTL and testbench

STATE_SEQUENCER -- requirements
Module: state_sequencer

---
 rtl/state_sequencer_pkg.sv | 13 +
 rtl/sat_counter.sv | 18 +
 rtl/state_sequencer.sv | 64 ++++++
 tb/tb_state_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/state_sequencer_pkg.sv
// Shared codes for the instruction-phase sequencer: phase encoding and halt address.
package state_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC1  = 2'd1,
    EXEC2  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [31:0] HALT_ADDR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-high clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                    count_o <= '0;
    else if (en && count_o != '1) count_o <= count_o + ONE;
  end

endmodule

// File: rtl/state_sequencer.sv
// Multi-cycle CPU phase sequencer (FETCH/EXEC1/EXEC2/HALTED).
// Define STATE_SEQ_PERF_CNT_EN to add retired-instruction and stall-cycle counters.
module state_sequencer
  import state_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        muldiv_busy_i,
  input  logic [31:0] pc_next_i,
  output state_t      state_o,
  output logic        active_o
`ifdef STATE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] retired_count_o,
  output logic [31:0] stall_count_o
`endif
);

  state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (!stall_i) state_d = EXEC1;
      EXEC1:   if (!stall_i) state_d = EXEC2;
      EXEC2:   if (!stall_i && !muldiv_busy_i)
                 state_d = (pc_next_i == HALT_ADDR) ? HALTED : FETCH;
      HALTED:  state_d = HALTED;
      default: state_d = HALTED;
    endcase
  end

  // active_o is registered off state_d so it drops on the same edge that enters HALTED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      active_o <= 1'b1;
    end else begin
      state_q  <= state_d;
      active_o <= (state_d != HALTED);
    end
  end

  assign state_o = state_q;

`ifdef STATE_SEQ_PERF_CNT_EN
  logic hold, retire;

  // Simultaneous stall and busy in EXEC2 is still a single lost cycle.
  assign hold   = ((state_q == FETCH || state_q == EXEC1) && stall_i) ||
                  ((state_q == EXEC2) && (stall_i || muldiv_busy_i));
  assign retire = (state_q == EXEC2) && !stall_i && !muldiv_busy_i;

  sat_counter #(.W(32)) u_retired (
    .clk(clk), .clr(reset), .en(retire), .count_o(retired_count_o)
  );

  sat_counter #(.W(32)) u_stall (
    .clk(clk), .clr(reset), .en(hold), .count_o(stall_count_o)
  );
`endif

endmodule

// File: tb/tb_state_sequencer.sv
// Scoreboard bench for state_sequencer: directed phase scenarios plus random traffic vs. a phase-level model.
module tb_state_sequencer;
  import state_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        muldiv_busy_i = 1'b0;
  logic [31:0] pc_next_i = 32'hBFC0_0004;
  state_t      state_o;
  logic        active_o;
`ifdef STATE_SEQ_PERF_CNT_EN
  logic [31:0] retired_count_o, stall_count_o;
`endif

  logic       sat_en = 1'b0;
  logic [1:0] sat_q;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  state_sequencer dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .muldiv_busy_i(muldiv_busy_i),
    .pc_next_i(pc_next_i), .state_o(state_o), .active_o(active_o)
`ifdef STATE_SEQ_PERF_CNT_EN
    , .retired_count_o(retired_count_o), .stall_count_o(stall_count_o)
`endif
  );

  // Narrow instance so saturation is reachable in a few cycles.
  sat_counter #(.W(2)) u_sat (.clk(clk), .clr(reset), .en(sat_en), .count_o(sat_q));

  typedef struct {
    int          ph;
    bit          act;
    logic [31:0] ret;
    logic [31:0] stl;
  } exp_t;

  exp_t q[$];

  // Phase-level model: 0=fetch 1=exec1 2=exec2 3=halted
  int          m_ph;
  logic [31:0] m_ret, m_stl;
  int          halt_cycles;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; entered and left just after a negedge.
  task automatic cyc(input bit s, input bit b, input logic [31:0] pc);
    bit waits;
    exp_t e;
    stall_i = s; muldiv_busy_i = b; pc_next_i = pc;
    if (m_ph != 3) begin
      waits = (m_ph == 2) ? (s || b) : s;
      if (waits) m_stl = sat_inc(m_stl);
      else if (m_ph == 2) begin
        m_ret = sat_inc(m_ret);
        m_ph  = (pc == 32'h0) ? 3 : 0;
      end else m_ph = m_ph + 1;
    end
    e.ph = m_ph; e.act = (m_ph != 3); e.ret = m_ret; e.stl = m_stl;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse, asserted mid-cycle and checked before the next edge.
  task automatic rst();
    #2 reset = 1'b1;
    #1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_active", active_o, 1);
    chk("rst_sat", sat_q, 0);
`ifdef STATE_SEQ_PERF_CNT_EN
    chk("rst_retired", retired_count_o, 0);
    chk("rst_stall", stall_count_o, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    m_ph = 0; m_ret = '0; m_stl = '0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", int'(state_o), e.ph);
        chk("active", active_o, e.act);
`ifdef STATE_SEQ_PERF_CNT_EN
        chk("retired", retired_count_o, e.ret);
        chk("stalls", stall_count_o, e.stl);
`endif
      end
    end
  end

  initial begin
    m_ph = 0; m_ret = '0; m_stl = '0;
    @(negedge clk);
    rst();

    // Back-to-back unstalled instructions, with the tiny counter run into saturation.
    sat_en = 1'b1;
    repeat (9) cyc(0, 0, 32'hBFC0_0004);
    sat_en = 1'b0;
    chk("sat_hold", sat_q, 3);

    // Stalls in FETCH and EXEC1.
    rst();
    repeat (2) cyc(1, 0, 32'h4);
    cyc(0, 0, 32'h4);
    repeat (3) cyc(1, 0, 32'h4);
    cyc(0, 0, 32'h4);
    cyc(0, 0, 32'h4);

    // Busy in EXEC2, overlapping stall on two of the cycles.
    rst();
    cyc(0, 0, 32'h8); cyc(0, 0, 32'h8);
    cyc(1, 1, 32'h8); cyc(0, 1, 32'h8); cyc(1, 1, 32'h8); cyc(0, 1, 32'h8);
    cyc(0, 0, 32'h8);

    // Halt address presented while stalled must not halt; then halt and ignore inputs.
    cyc(0, 0, 32'h0); cyc(0, 0, 32'h0);
    cyc(1, 0, 32'h0); cyc(1, 0, 32'h0);
    cyc(0, 0, 32'h0);
    repeat (20) cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));

    // Reset mid-EXEC1 and resume.
    rst();
    cyc(0, 0, 32'h10);
    rst();
    repeat (6) cyc(0, 0, 32'h10);

    // Random traffic.
    rst();
    halt_cycles = 0;
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom);
      if (m_ph == 3) halt_cycles++;
      if (halt_cycles > 5) begin
        halt_cycles = 0;
        rst();
      end
    end

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
